// File: rtl/loadip_multibuf_if.sv
// Producer/consumer handshake bundle for the N-bank load-input buffer.
// The slave modport is the buffer itself; the master modport is the front end/datapath side.
interface loadip_multibuf_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BANKS  = 4
);
    localparam int BANK_W = $clog2(NUM_BANKS);

    logic                  o_wr_ready;
    logic                  i_wr_activate;
    logic [BANK_W-1:0]     o_wr_bank;
    logic                  i_wstrobe;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic [15:0]           o_wr_fifo_size;
    logic                  o_overflow;

    logic                  o_rd_ready;
    logic                  i_rd_activate;
    logic [BANK_W-1:0]     o_rd_bank;
    logic [15:0]           o_rd_cnt;
    logic                  i_rstrobe;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_rvalid;
    logic                  o_starved;
    logic [BANK_W:0]       o_banks_free;
    logic                  o_inactivate;

    modport slave (
        output o_wr_ready, o_wr_bank, o_wr_fifo_size, o_overflow,
        output o_rd_ready, o_rd_bank, o_rd_cnt, o_rdata, o_rvalid,
        output o_starved, o_banks_free, o_inactivate,
        input  i_wr_activate, i_wstrobe, i_wdata, i_rd_activate, i_rstrobe
    );

    modport master (
        input  o_wr_ready, o_wr_bank, o_wr_fifo_size, o_overflow,
        input  o_rd_ready, o_rd_bank, o_rd_cnt, o_rdata, o_rvalid,
        input  o_starved, o_banks_free, o_inactivate,
        output i_wr_activate, i_wstrobe, i_wdata, i_rd_activate, i_rstrobe
    );
endinterface

// File: rtl/loadip_multibuf.sv
// N-bank ring buffer between the load-input front end and the compute datapath.
// Banks cycle FREE -> FILLING -> FULL -> DRAINING -> FREE; each side owns its own transitions.
module loadip_multibuf #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_BANKS  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    loadip_multibuf_if.slave io_bus
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam int RAM_N  = NUM_BANKS * DEPTH;

    typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_DRAINING} bank_state_e;
    typedef enum logic {W_IDLE, W_ACTIVE} wr_state_e;
    typedef enum logic {R_IDLE, R_ACTIVE} rd_state_e;

    wr_state_e             r_wr_state, w_wr_state_nxt;
    rd_state_e             r_rd_state, w_rd_state_nxt;
    bank_state_e           r_bank_state [NUM_BANKS];
    logic [CNT_W-1:0]      r_size       [NUM_BANKS];
    logic [DATA_WIDTH-1:0] r_mem        [RAM_N];

    logic [BANK_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]      r_wr_cnt, r_rd_off;
    logic                  r_overflow, r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_wr_ready, w_rd_ready, w_wr_full;
    logic                  w_wr_claim, w_wr_commit, w_wr_discard, w_wr_en, w_ovf_set;
    logic                  w_rd_claim, w_rd_release, w_rd_en;
    logic [ADDR_WIDTH-1:0] w_wr_off;
    logic [BANK_W:0]       w_banks_free;

    assign w_wr_ready = (r_wr_state == W_IDLE) && (r_bank_state[r_wr_ptr] == B_FREE);
    assign w_rd_ready = (r_rd_state == R_IDLE) && (r_bank_state[r_rd_ptr] == B_FULL);
    assign w_wr_full  = (r_wr_cnt == CNT_W'(DEPTH));
    // A strobe on the claim cycle lands at offset 0 regardless of the stale count
    assign w_wr_off   = w_wr_claim ? '0 : r_wr_cnt[ADDR_WIDTH-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_state <= W_IDLE;
            r_rd_state <= R_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_claim     = 1'b0;
        w_wr_commit    = 1'b0;
        w_wr_discard   = 1'b0;
        w_wr_en        = 1'b0;
        w_ovf_set      = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (io_bus.i_wr_activate && w_wr_ready) begin
                    w_wr_state_nxt = W_ACTIVE;
                    w_wr_claim     = 1'b1;
                    w_wr_en        = io_bus.i_wstrobe;
                end
            end
            W_ACTIVE: begin
                // Dropping activate closes the bank; a strobe on that same cycle is not taken
                if (!io_bus.i_wr_activate) begin
                    w_wr_state_nxt = W_IDLE;
                    if (r_wr_cnt != '0) w_wr_commit  = 1'b1;
                    else                w_wr_discard = 1'b1;
                end else if (io_bus.i_wstrobe) begin
                    if (w_wr_full) w_ovf_set = 1'b1;
                    else           w_wr_en   = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_claim     = 1'b0;
        w_rd_release   = 1'b0;
        w_rd_en        = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (io_bus.i_rd_activate && w_rd_ready) begin
                    w_rd_state_nxt = R_ACTIVE;
                    w_rd_claim     = 1'b1;
                end
            end
            R_ACTIVE: begin
                w_rd_en = io_bus.i_rstrobe && (r_rd_off < r_size[r_rd_ptr]);
                if (!io_bus.i_rd_activate) begin
                    w_rd_state_nxt = R_IDLE;
                    w_rd_release   = 1'b1;
                end
            end
        endcase
    end

    // Write and read sides only ever touch distinct banks, so their updates never collide
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                r_bank_state[i] <= B_FREE;
                r_size[i]       <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wr_cnt   <= '0;
            r_rd_off   <= '0;
            r_overflow <= 1'b0;
            r_rvalid   <= 1'b0;
        end else begin
            if (w_wr_claim) begin
                r_bank_state[r_wr_ptr] <= B_FILLING;
                r_wr_cnt               <= w_wr_en ? CNT_W'(1) : '0;
            end else if (w_wr_en) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
            if (w_wr_commit) begin
                r_bank_state[r_wr_ptr] <= B_FULL;
                r_size[r_wr_ptr]       <= r_wr_cnt;
                r_wr_ptr               <= r_wr_ptr + BANK_W'(1);
            end
            if (w_wr_discard) r_bank_state[r_wr_ptr] <= B_FREE;
            if (w_ovf_set)    r_overflow <= 1'b1;

            if (w_rd_claim) begin
                r_bank_state[r_rd_ptr] <= B_DRAINING;
                r_rd_off               <= '0;
            end else if (w_rd_en) begin
                r_rd_off <= r_rd_off + CNT_W'(1);
            end
            if (w_rd_release) begin
                r_bank_state[r_rd_ptr] <= B_FREE;
                r_rd_ptr               <= r_rd_ptr + BANK_W'(1);
            end
            r_rvalid <= w_rd_en;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[{r_wr_ptr, w_wr_off}] <= io_bus.i_wdata;
        if (w_rd_en) r_rdata <= r_mem[{r_rd_ptr, r_rd_off[ADDR_WIDTH-1:0]}];
    end

    always_comb begin
        w_banks_free = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (r_bank_state[i] == B_FREE) w_banks_free = w_banks_free + (BANK_W+1)'(1);
        end
    end

    assign io_bus.o_wr_ready     = w_wr_ready;
    assign io_bus.o_wr_bank      = r_wr_ptr;
    assign io_bus.o_wr_fifo_size = 16'(DEPTH);
    assign io_bus.o_overflow     = r_overflow;
    assign io_bus.o_rd_ready     = w_rd_ready;
    assign io_bus.o_rd_bank      = r_rd_ptr;
    assign io_bus.o_rd_cnt       = (r_bank_state[r_rd_ptr] == B_FULL ||
                                    r_bank_state[r_rd_ptr] == B_DRAINING) ?
                                   16'(r_size[r_rd_ptr]) : '0;
    assign io_bus.o_rdata        = r_rdata;
    assign io_bus.o_rvalid       = r_rvalid;
    assign io_bus.o_starved      = !w_rd_ready && (r_rd_state == R_IDLE);
    assign io_bus.o_banks_free   = w_banks_free;
    assign io_bus.o_inactivate   = (w_banks_free == (BANK_W+1)'(NUM_BANKS)) &&
                                   (r_wr_state == W_IDLE) && (r_rd_state == R_IDLE);
endmodule

// File: tb/tb_loadip_multibuf.sv
// Bench for loadip_multibuf: queue-level reference model checked every cycle,
// directed scenarios with literal expectations, and a second small-depth instance for overflow.
module tb_loadip_multibuf;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NB = 4;
    localparam int DEPTH_M = 2 ** AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    loadip_multibuf_if #(.DATA_WIDTH(DW), .NUM_BANKS(NB)) bus ();
    loadip_multibuf_if #(.DATA_WIDTH(DW), .NUM_BANKS(NB)) bus2 ();

    loadip_multibuf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) u_dut (
        .i_clk(clk), .i_rst(rst), .io_bus(bus));
    loadip_multibuf #(.DATA_WIDTH(DW), .ADDR_WIDTH(2), .NUM_BANKS(NB)) u_dut2 (
        .i_clk(clk), .i_rst(rst2), .io_bus(bus2));

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: committed banks as a queue of sizes plus a flat word queue
    int          qsize[$];
    logic [7:0]  qdata[$];
    logic [7:0]  fillq[$];
    bit          wact, ract, m_ovf, m_rvalid;
    logic [7:0]  m_rdata;
    int          wcommits, rrel, rd_off, rd_size;
    logic [7:0]  got[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit wr_rdy, rd_rdy;
        if (rst) begin
            qsize.delete(); qdata.delete(); fillq.delete();
            wact = 0; ract = 0; m_ovf = 0; m_rvalid = 0;
            wcommits = 0; rrel = 0; rd_off = 0; rd_size = 0;
            return;
        end
        wr_rdy = !wact && (qsize.size() + int'(ract)) < NB;
        rd_rdy = !ract && qsize.size() > 0;
        m_rvalid = 0;
        if (ract) begin
            if (bus.i_rstrobe && rd_off < rd_size) begin
                m_rvalid = 1;
                m_rdata  = qdata[rd_off];
                rd_off++;
            end
            if (!bus.i_rd_activate) begin
                repeat (rd_size) void'(qdata.pop_front());
                ract = 0;
                rrel++;
            end
        end else if (bus.i_rd_activate && rd_rdy) begin
            ract    = 1;
            rd_size = qsize.pop_front();
            rd_off  = 0;
        end
        if (wact) begin
            if (!bus.i_wr_activate) begin
                if (fillq.size() > 0) begin
                    qsize.push_back(fillq.size());
                    foreach (fillq[i]) qdata.push_back(fillq[i]);
                    wcommits++;
                end
                fillq.delete();
                wact = 0;
            end else if (bus.i_wstrobe) begin
                if (fillq.size() < DEPTH_M) fillq.push_back(bus.i_wdata);
                else m_ovf = 1;
            end
        end else if (bus.i_wr_activate && wr_rdy) begin
            wact = 1;
            fillq.delete();
            if (bus.i_wstrobe) fillq.push_back(bus.i_wdata);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #2;
        if (bus.o_rvalid === 1'b1) got.push_back(bus.o_rdata);
    endtask

    always @(negedge clk) begin
        int  occ;
        bit  e_rd_rdy;
        if (chk_en) begin
            occ      = qsize.size() + int'(ract);
            e_rd_rdy = !ract && qsize.size() > 0;
            check("wr_ready",   bus.o_wr_ready, !wact && occ < NB);
            check("wr_bank",    bus.o_wr_bank, wcommits % NB);
            check("rd_ready",   bus.o_rd_ready, e_rd_rdy);
            check("rd_bank",    bus.o_rd_bank, rrel % NB);
            if (e_rd_rdy) check("rd_cnt", bus.o_rd_cnt, qsize[0]);
            check("overflow",   bus.o_overflow, m_ovf);
            check("rvalid",     bus.o_rvalid, m_rvalid);
            if (m_rvalid) check("rdata", bus.o_rdata, m_rdata);
            check("starved",    bus.o_starved, !e_rd_rdy && !ract);
            check("banks_free", bus.o_banks_free, NB - occ - int'(wact));
            check("inactivate", bus.o_inactivate, occ == 0 && !wact);
            check("fifo_size",  bus.o_wr_fifo_size, DEPTH_M);
        end
    end

    task automatic clear_inputs();
        bus.i_wr_activate = 0; bus.i_wstrobe = 0; bus.i_wdata = '0;
        bus.i_rd_activate = 0; bus.i_rstrobe = 0;
    endtask

    task automatic do_reset();
        rst = 1; clear_inputs(); step(); rst = 0;
    endtask

    task automatic write_bank(int n, int base);
        bus.i_wr_activate = 1; step();
        for (int i = 0; i < n; i++) begin
            bus.i_wstrobe = 1; bus.i_wdata = 8'(base + i); step();
        end
        bus.i_wstrobe = 0; bus.i_wr_activate = 0; step();
    endtask

    task automatic read_bank(int n);
        bus.i_rd_activate = 1; step();
        for (int i = 0; i < n; i++) begin
            bus.i_rstrobe = 1; step();
        end
        bus.i_rstrobe = 0; bus.i_rd_activate = 0; step();
    endtask

    initial begin
        logic [7:0] got2[$];
        clear_inputs();
        bus2.i_wr_activate = 0; bus2.i_wstrobe = 0; bus2.i_wdata = '0;
        bus2.i_rd_activate = 0; bus2.i_rstrobe = 0;

        // Reset values
        do_reset();
        chk_en = 1;
        check("rst_inactivate", bus.o_inactivate, 1);
        check("rst_banks_free", bus.o_banks_free, 4);
        check("rst_wr_ready",   bus.o_wr_ready, 1);
        check("rst_rd_ready",   bus.o_rd_ready, 0);
        check("rst_rd_cnt",     bus.o_rd_cnt, 0);

        // Single bank commit
        write_bank(5, 0);
        check("t1_rd_ready",   bus.o_rd_ready, 1);
        check("t1_rd_cnt",     bus.o_rd_cnt, 5);
        check("t1_banks_free", bus.o_banks_free, 3);

        // Fill all banks then drain in order
        do_reset();
        for (int b = 0; b < 4; b++) write_bank(3, 3 * b);
        check("t2_wr_ready",   bus.o_wr_ready, 0);
        check("t2_banks_free", bus.o_banks_free, 0);
        got.delete();
        for (int b = 0; b < 4; b++) read_bank(3);
        check("t2_rvalid_cnt", got.size(), 12);
        for (int i = 0; i < 12 && i < got.size(); i++) check("t2_data", got[i], i);
        check("t2_rd_bank_wrap", bus.o_rd_bank, 0);
        check("t2_inactivate",   bus.o_inactivate, 1);

        // Empty claim/release
        do_reset();
        bus.i_wr_activate = 1; step();
        check("t4_claimed_free", bus.o_banks_free, 3);
        bus.i_wr_activate = 0; step();
        check("t4_wr_bank",    bus.o_wr_bank, 0);
        check("t4_banks_free", bus.o_banks_free, 4);
        check("t4_rd_ready",   bus.o_rd_ready, 0);

        // Partial read then over-strobed read
        do_reset();
        write_bank(6, 100);
        write_bank(6, 200);
        got.delete();
        read_bank(2);
        check("t5_partial_cnt", got.size(), 2);
        check("t5_next_bank",   bus.o_rd_bank, 1);
        check("t5_next_cnt",    bus.o_rd_cnt, 6);
        check("t5_banks_free",  bus.o_banks_free, 3);
        got.delete();
        read_bank(7);
        check("t5_rvalid_cnt", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) check("t5_data", got[i], 200 + i);

        // Reset while both sides are active
        do_reset();
        write_bank(3, 50);
        bus.i_wr_activate = 1; bus.i_rd_activate = 1; step();
        bus.i_wstrobe = 1; bus.i_rstrobe = 1; step();
        rst = 1; step();
        check("t6_inactivate", bus.o_inactivate, 1);
        check("t6_wr_ready",   bus.o_wr_ready, 1);
        check("t6_rd_ready",   bus.o_rd_ready, 0);
        check("t6_rvalid",     bus.o_rvalid, 0);
        check("t6_banks_free", bus.o_banks_free, 4);
        check("t6_rd_cnt",     bus.o_rd_cnt, 0);
        rst = 0; clear_inputs(); step();

        // Overflow on the 4-word instance
        step(); rst2 = 0;
        bus2.i_wr_activate = 1; step();
        for (int i = 0; i < 5; i++) begin
            bus2.i_wstrobe = 1; bus2.i_wdata = 8'(10 + i); step();
        end
        check("t3_ovf_set", bus2.o_overflow, 1);
        bus2.i_wstrobe = 0; bus2.i_wr_activate = 0; step();
        check("t3_ovf_sticky", bus2.o_overflow, 1);
        check("t3_rd_cnt",     bus2.o_rd_cnt, 4);
        check("t3_fifo_size",  bus2.o_wr_fifo_size, 4);
        bus2.i_rd_activate = 1; step();
        bus2.i_rstrobe = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) bus2.i_rstrobe = 0;
            step();
            if (bus2.o_rvalid === 1'b1) got2.push_back(bus2.o_rdata);
        end
        check("t3_rvalid_cnt", got2.size(), 4);
        for (int i = 0; i < 4 && i < got2.size(); i++) check("t3_data", got2[i], 10 + i);
        bus2.i_rd_activate = 0; step();
        check("t3_ovf_after", bus2.o_overflow, 1);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) bus.i_wr_activate = !bus.i_wr_activate;
            if ($urandom_range(0, 5) == 0) bus.i_rd_activate = !bus.i_rd_activate;
            bus.i_wstrobe = 1'($urandom_range(0, 1));
            bus.i_rstrobe = 1'($urandom_range(0, 1));
            bus.i_wdata   = 8'($urandom);
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
